// File: rtl/rst_pkg.sv
// Shared types for the reset-request generator: cause encoding and FSM states.
package rst_pkg;

  typedef enum logic [1:0] {
    RST_POR = 2'd0,
    RST_BTN = 2'd1,
    RST_SW  = 2'd2,
    RST_WDT = 2'd3
  } rst_cause_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } rst_req_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_req_gen_if.sv
// Reset-source inputs and request outputs of rst_req_gen, bundled for the block boundary.
interface rst_req_gen_if;
  import rst_pkg::*;

  logic       btn_n;
  logic       sw_rst_req;
  logic       wdt_en;
  logic       wdt_kick;
  logic       async_nrst;
  rst_cause_e rst_cause;
  logic       busy;

  modport master (
    output btn_n, sw_rst_req, wdt_en, wdt_kick,
    input  async_nrst, rst_cause, busy
  );

  modport slave (
    input  btn_n, sw_rst_req, wdt_en, wdt_kick,
    output async_nrst, rst_cause, busy
  );
endinterface

// File: rtl/rst_debounce.sv
// Push-button synchronizer and debouncer: one press pulse per stable-low hold.
module rst_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_press_c
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_TERM = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_armed;

  // Counter wraps to zero at its terminal value; disarming keeps a held button to one press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      if (r_sync2) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else if (r_cnt == C_TERM) begin
        r_cnt   <= '0;
        r_armed <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press_c = ~r_sync2 & r_armed & (r_cnt == C_TERM);

endmodule

// File: rtl/rst_req_gen.sv
// Merges POR, button, software and watchdog sources into one minimum-width reset request.
// Watchdog logic is present only when RST_REQ_WDT_EN is defined.
module rst_req_gen
  import rst_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 64,
  parameter int unsigned WDT_TIMEOUT     = 1 << 20
) (
  input  logic          clk,
  input  logic          rst,
  rst_req_gen_if.slave  bus
);
  localparam int unsigned CW = $clog2(max_u(PULSE_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam logic [CW-1:0] C_PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);

  rst_req_state_e r_state;
  rst_req_state_e w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  rst_cause_e     r_cause;
  rst_cause_e     w_cause_nxt;
  logic           r_nrst;
  logic           r_busy;
  logic           w_btn_evt;
  logic           w_wdt_evt;

  rst_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .i_btn_n   (bus.btn_n),
    .o_press_c (w_btn_evt)
  );

`ifdef RST_REQ_WDT_EN
  localparam int unsigned WW = $clog2(WDT_TIMEOUT + 1);
  localparam logic [WW-1:0] C_WDT_LAST = WW'(WDT_TIMEOUT - 1);

  logic [WW-1:0] r_wdt_cnt;

  // A kick in the terminal cycle suppresses the event.
  assign w_wdt_evt = (r_state == IDLE) & bus.wdt_en & ~bus.wdt_kick & (r_wdt_cnt == C_WDT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdt_cnt <= '0;
    end else if ((r_state != IDLE) || !bus.wdt_en || bus.wdt_kick || (r_wdt_cnt == C_WDT_LAST)) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + WW'(1);
    end
  end
`else
  logic w_unused_wdt;
  assign w_unused_wdt = ^{bus.wdt_en, bus.wdt_kick, 32'(WDT_TIMEOUT)};
  assign w_wdt_evt    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    unique case (r_state)
      IDLE: begin
        if (w_wdt_evt || w_btn_evt || bus.sw_rst_req) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = '0;
          if (w_wdt_evt)      w_cause_nxt = RST_WDT;
          else if (w_btn_evt) w_cause_nxt = RST_BTN;
          else                w_cause_nxt = RST_SW;
        end
      end
      ASSERT: begin
        if (r_cnt == C_PULSE_LAST) begin
          w_state_nxt = HOLDOFF;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      HOLDOFF: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ASSERT;
      r_cnt   <= '0;
      r_cause <= RST_POR;
      r_nrst  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= w_cause_nxt;
      r_nrst  <= (w_state_nxt != ASSERT);
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign bus.async_nrst = r_nrst;
  assign bus.rst_cause  = r_cause;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_rst_req_gen.sv
// Scoreboard bench for rst_req_gen: stimulus pushes expected pulses, a monitor checks them.
module tb_rst_req_gen;
  import rst_pkg::*;

  localparam int PULSE = 4;
`ifdef RST_REQ_WDT_EN
  localparam int WDT_ON = 1;
`else
  localparam int WDT_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rst_req_gen_if bus();

  rst_req_gen #(
    .DEBOUNCE_CYCLES (8),
    .PULSE_CYCLES    (4),
    .HOLDOFF_CYCLES  (6),
    .WDT_TIMEOUT     (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int    start;
    int    cause;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic push(input int start, input int cause, input string name);
    exp_t e;
    e.start = start;
    e.cause = cause;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (bus.busy && k < 300) begin
      tick(1);
      k++;
    end
    check({name, "_idle"}, int'(bus.busy), 0);
  endtask

  // Monitor: measure each low pulse on async_nrst and compare against the queue head.
  initial begin : monitor
    bit   in_pulse = 1'b0;
    int   start = 0;
    int   width = 0;
    int   cause = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pulse = 1'b1;
        start    = -1;
        width    = 0;
      end else if (!bus.async_nrst) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          start    = cyc;
          width    = 0;
        end
        if (width == 0) cause = int'(bus.rst_cause);
        width++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: start=%0d cause=%0d, expected no pulse", start, cause);
        end else begin
          e = exp_q.pop_front();
          if (e.start >= 0) check({e.name, "_start"}, start, e.start);
          check({e.name, "_width"}, width, PULSE);
          check({e.name, "_cause"}, cause, e.cause);
        end
      end
    end
  end

  initial begin : timeout
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst            = 1'b1;
    bus.btn_n      = 1'b1;
    bus.sw_rst_req = 1'b0;
    bus.wdt_en     = 1'b0;
    bus.wdt_kick   = 1'b0;

    // 1: power-on pulse and holdoff
    push(-1, 0, "t1_por");
    tick(3);
    rst = 1'b0;
    n = cyc;
    at_neg(n + 9);
    check("t1_busy_holdoff", int'(bus.busy), 1);
    at_neg(n + 10);
    check("t1_busy_idle", int'(bus.busy), 0);
    check("t1_cause", int'(bus.rst_cause), 0);
    tick(1);
    check("t1_queue", exp_q.size(), 0);

    // 2: bouncing button, then a stable hold
    for (int i = 0; i < 10; i++) begin
      bus.btn_n = i[0];
      tick(3);
    end
    bus.btn_n = 1'b0;
    n = cyc;
    push(n + 11, 1, "t2_btn");
    tick(40);
    bus.btn_n = 1'b1;
    wait_idle("t2");
    check("t2_cause", int'(bus.rst_cause), 1);
    check("t2_queue", exp_q.size(), 0);
    tick(4);

    // 3: software request, second request during holdoff is dropped
    bus.sw_rst_req = 1'b1;
    n = cyc;
    push(n + 1, 2, "t3_sw");
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(6);
    check("t3_in_holdoff", int'(bus.busy), 1);
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    wait_idle("t3");
    check("t3_cause", int'(bus.rst_cause), 2);
    check("t3_nrst", int'(bus.async_nrst), 1);
    check("t3_queue", exp_q.size(), 0);

    // 4: watchdog timeout, regular kicks, kick on the terminal cycle
    bus.wdt_en = 1'b1;
    n = cyc;
    if (WDT_ON != 0) push(n + 20, 3, "t4_wdt");
    tick(21);
    bus.wdt_en = 1'b0;
    wait_idle("t4a");
    check("t4a_cause", int'(bus.rst_cause), (WDT_ON != 0) ? 3 : 2);
    bus.wdt_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick(14);
      bus.wdt_kick = 1'b1;
      tick(1);
      bus.wdt_kick = 1'b0;
    end
    bus.wdt_en = 1'b0;
    tick(2);
    bus.wdt_en = 1'b1;
    tick(19);
    bus.wdt_kick = 1'b1;
    tick(1);
    bus.wdt_kick = 1'b0;
    bus.wdt_en   = 1'b0;
    tick(3);
    check("t4_kick_busy", int'(bus.busy), 0);
    check("t4_queue", exp_q.size(), 0);

    // 5: software and watchdog requests in the same cycle
    bus.wdt_en = 1'b1;
    n = cyc;
    tick(19);
    bus.sw_rst_req = 1'b1;
    push(n + 20, (WDT_ON != 0) ? 3 : 2, "t5_both");
    tick(1);
    bus.sw_rst_req = 1'b0;
    bus.wdt_en     = 1'b0;
    wait_idle("t5");
    check("t5_queue", exp_q.size(), 0);

    // 6: power-on reset in the middle of a software pulse
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(1);
    push(-1, 0, "t6_por");
    rst = 1'b1;
    at_neg(cyc);
    check("t6_nrst_low", int'(bus.async_nrst), 0);
    check("t6_cause_por", int'(bus.rst_cause), 0);
    tick(2);
    rst = 1'b0;
    wait_idle("t6");
    tick(2);
    check("t6_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
